multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle main control FSM; drives the ALU control interface (ALUOp, ALUSrc, funct3/funct7) and consumes the ALU `zero` flag.
- Sequences fetch/decode/execute/memory/writeback for the RV32I subset the ALU supports (add, sub, and, or, addi, lw, sw, beq).
- Sits between instruction/data memory handshakes and the datapath enables (PC, IR, register file, memory).

Parameters:
- RESET_STATE, 3'd0, encoding of FETCH entered on reset.
- MEM_TIMEOUT, 16, max cycles waiting on MemReady before FAULT; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Instr  in  32  instruction word from instruction memory, valid when MemReady is high in FETCH.
- MemReady  in  1  memory handshake; completes the current FETCH or MEM access.
- zero  in  1  ALU zero flag, sampled in EXEC for beq.
- ALUOp  out  2  ALU op class: 00 add, 01 sub, 10 R-type decode.
- ALUSrc  out  1  0 = ReadData2, 1 = imm32.
- funct3  out  3  latched IR[14:12].
- funct7  out  7  latched IR[31:25].
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  update PC.
- PCSrc  out  1  0 = PC+4, 1 = branch target.
- MemRead  out  1  data/instruction read request.
- MemWrite  out  1  data write request.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  writeback select: 0 = ALUResult, 1 = load data.
- Fault  out  1  sticky illegal-opcode or timeout flag.
- State  out  3  current state, for debug.

Behaviour:
- Reset (async, rst_n low):
  - State = FETCH; IR = 0.
  - Fault = 0; all enables and ALUOp/ALUSrc/funct fields are 0.
  - A reset mid-access aborts the access immediately; no partial writes.
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), FAULT(7). Outputs are Moore (decoded from state and IR), except IRWrite/PCWrite in FETCH and MEM handshake completion.
- FETCH:
  - MemRead = 1.
  - Stay while MemReady = 0.
  - On MemReady = 1: IRWrite = 1, PCWrite = 1, PCSrc = 0, latch Instr, then go to DECODE.
- DECODE:
  - Classify opcode IR[6:0]: 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ.
  - Any other opcode sets Fault and goes to FAULT. Otherwise go to EXEC.
- EXEC:
  - R: ALUOp = 10, ALUSrc = 0, then WB.
  - I-ALU: ALUOp = 00, ALUSrc = 1, then WB. Only funct3 = 000 (addi) is legal; anything else goes to FAULT.
  - LW/SW: ALUOp = 00, ALUSrc = 1, then MEM.
  - BEQ: ALUOp = 01, ALUSrc = 0. If zero = 1, PCWrite = 1 and PCSrc = 1. Then FETCH.
- MEM:
  - LW asserts MemRead; SW asserts MemWrite.
  - Hold until MemReady = 1.
  - LW then goes to WB; SW then goes to FETCH.
- WB:
  - RegWrite = 1; MemtoReg = 1 for LW, else 0.
  - Then FETCH.
- Latency, with zero memory wait states (MemReady = 1 in the cycle the request is raised):
  - R / I-ALU / SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ: 3 cycles.
- Timeout:
  - Wait counter resets on entry to FETCH or MEM and counts cycles with MemReady = 0.
  - Reaching MEM_TIMEOUT sets Fault and goes to FAULT.
- FAULT:
  - Absorbing; all enables are 0.
  - Exits only via rst_n.
- Enable rules:
  - RegWrite, MemWrite and PCWrite are never asserted in the same cycle.
  - MemRead and MemWrite are mutually exclusive.
- funct3/funct7 are driven from the latched IR, stable from DECODE through WB.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined:
  - Adds output ports CycleCount[31:0] and RetireCount[31:0], both reset to 0.
  - CycleCount increments every cycle outside FAULT.
  - RetireCount increments on the last state of each instruction (WB exit, SW MEM completion, BEQ EXEC).
  - Both counters wrap modulo 2^32.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- add x3,x1,x2 (0x002081B3), MemReady always 1:
  - States FETCH-DECODE-EXEC-WB.
  - ALUOp = 10, ALUSrc = 0 in EXEC; RegWrite = 1 for exactly one cycle; funct7 = 0000000, funct3 = 000.
- lw x5,8(x1) (0x0080A283), MemReady low for 3 cycles in MEM:
  - MEM held 4 cycles, MemRead high throughout.
  - WB has MemtoReg = 1; 8 cycles total.
- beq x1,x2,+8 (0x00208463):
  - zero = 1: PCWrite = 1 and PCSrc = 1 in EXEC.
  - zero = 0: no PCWrite in EXEC.
  - Back in FETCH after 3 cycles either way.
- Illegal opcode 0x0000007F:
  - DECODE goes to FAULT; Fault = 1 sticky; no enables afterwards.
  - rst_n pulse returns to FETCH with Fault = 0.
- rst_n asserted mid-MEM of sw (0x0020A423):
  - MemWrite drops asynchronously before the next clk edge; State = 0.
- With MULTICYCLE_CTRL_PERF_EN: run add, lw, beq back-to-back, zero wait states.
  - RetireCount = 3; CycleCount = 12.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> memory/datapath/ALU signal bundle for multicycle_ctrl.
// master = the control FSM, slave = memories and datapath.
interface multicycle_ctrl_if;
  logic [31:0] Instr;
  logic        MemReady;
  logic        zero;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic        Fault;
  logic [2:0]  State;

  modport master (
    input  Instr, MemReady, zero,
    output ALUOp, ALUSrc, funct3, funct7, IRWrite, PCWrite, PCSrc,
           MemRead, MemWrite, RegWrite, MemtoReg, Fault, State
  );

  modport slave (
    output Instr, MemReady, zero,
    input  ALUOp, ALUSrc, funct3, funct7, IRWrite, PCWrite, PCSrc,
           MemRead, MemWrite, RegWrite, MemtoReg, Fault, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset main control FSM (add/sub/and/or/addi/lw/sw/beq).
// Optional MULTICYCLE_CTRL_PERF_EN adds CycleCount/RetireCount outputs.
module multicycle_ctrl #(
  parameter logic [2:0]  RESET_STATE = 3'd0,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]       CycleCount,
  output logic [31:0]       RetireCount
`endif
);

  localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [2:0] S_FETCH  = RESET_STATE;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [2:0]    state, state_nxt;
  logic [6:0]    ir_op;
  logic [2:0]    ir_f3;
  logic [6:0]    ir_f7;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          mem_phase, wait_expired;
  logic          is_r, is_i, is_lw, is_sw, is_beq, is_legal;
  logic          unused_instr;

  // Only opcode and funct fields of the instruction matter to control.
  assign unused_instr = ^{bus.Instr[24:15], bus.Instr[11:7]};

  always_comb begin
    is_r     = (ir_op == OP_R);
    is_i     = (ir_op == OP_I);
    is_lw    = (ir_op == OP_LW);
    is_sw    = (ir_op == OP_SW);
    is_beq   = (ir_op == OP_BEQ);
    is_legal = is_r | is_i | is_lw | is_sw | is_beq;
  end

  // Memory wait tracking; a timeout of 0 never expires.
  assign mem_phase    = (state == S_FETCH) || (state == S_MEM);
  assign wait_expired = (MEM_TIMEOUT != 0) && mem_phase && !bus.MemReady &&
                        ((32'(wait_cnt) + 32'd1) == 32'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (wait_expired)      state_nxt = S_FAULT;
        else if (bus.MemReady) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = is_legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (is_r)               state_nxt = S_WB;
        else if (is_i)          state_nxt = (ir_f3 == 3'b000) ? S_WB : S_FAULT;
        else if (is_lw | is_sw) state_nxt = S_MEM;
        else if (is_beq)        state_nxt = S_FETCH;
        else                    state_nxt = S_FAULT;
      end
      S_MEM: begin
        if (wait_expired)      state_nxt = S_FAULT;
        else if (bus.MemReady) state_nxt = is_lw ? S_WB : S_FETCH;
      end
      S_WB:    state_nxt = S_FETCH;
      default: state_nxt = S_FAULT;
    endcase
  end

  // Enables are held low while rst_n is asserted so a reset aborts any access at once.
  always_comb begin
    bus.ALUOp    = 2'b00;
    bus.ALUSrc   = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSrc    = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemtoReg = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = bus.MemReady;
          bus.PCWrite = bus.MemReady;
        end
        S_EXEC: begin
          if (is_r) begin
            bus.ALUOp = 2'b10;
          end else if (is_i | is_lw | is_sw) begin
            bus.ALUSrc = 1'b1;
          end else if (is_beq) begin
            bus.ALUOp   = 2'b01;
            bus.PCWrite = bus.zero;
            bus.PCSrc   = bus.zero;
          end
        end
        S_MEM: begin
          bus.MemRead  = is_lw;
          bus.MemWrite = is_sw;
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = is_lw;
        end
        default: ;
      endcase
    end
  end

  assign bus.funct3 = ir_f3;
  assign bus.funct7 = ir_f7;
  assign bus.State  = state;
  assign bus.Fault  = (state == S_FAULT);

  // Counter restarts whenever a new state is entered.
  always_comb begin
    if (state_nxt != state)          wait_cnt_nxt = '0;
    else if (mem_phase && !bus.MemReady) wait_cnt_nxt = wait_cnt + CW'(1);
    else                             wait_cnt_nxt = wait_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_op    <= '0;
      ir_f3    <= '0;
      ir_f7    <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if ((state == S_FETCH) && bus.MemReady) begin
        ir_op <= bus.Instr[6:0];
        ir_f3 <= bus.Instr[14:12];
        ir_f7 <= bus.Instr[31:25];
      end
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;
  assign retire = (state == S_WB) ||
                  ((state == S_MEM) && is_sw && bus.MemReady) ||
                  ((state == S_EXEC) && is_beq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CycleCount  <= '0;
      RetireCount <= '0;
    end else begin
      if (state != S_FAULT) CycleCount <= CycleCount + 32'd1;
      if (retire)           RetireCount <= RetireCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model expands each
// instruction into per-cycle stimulus and expected outputs, checked every cycle.
module tb_multicycle_ctrl;
  localparam int unsigned TO = 16;

  localparam logic [6:0] EN_IRW = 7'b1000000;
  localparam logic [6:0] EN_PCW = 7'b0100000;
  localparam logic [6:0] EN_PCS = 7'b0010000;
  localparam logic [6:0] EN_MRD = 7'b0001000;
  localparam logic [6:0] EN_MWR = 7'b0000100;
  localparam logic [6:0] EN_RW  = 7'b0000010;
  localparam logic [6:0] EN_M2R = 7'b0000001;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_XORI = 32'h0040C093;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  multicycle_ctrl #(.RESET_STATE(3'd0), .MEM_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .CycleCount(cyc_cnt),
    .RetireCount(ret_cnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic        ready;
    logic        z;
    logic [23:0] outs;
    int unsigned cyc;
    int unsigned ret;
  } ent_t;

  ent_t        plan[$];
  ent_t        cur;
  bit          cmp_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          step = 0;
  int          mem_rd_cyc = 0;
  int          rw_cyc = 0;
  logic [31:0] m_ir = '0;
  int unsigned m_cyc = 0;
  int unsigned m_ret = 0;

  logic [23:0] dut_outs;
  assign dut_outs = {bus.State, bus.ALUOp, bus.ALUSrc, bus.IRWrite, bus.PCWrite,
                     bus.PCSrc, bus.MemRead, bus.MemWrite, bus.RegWrite,
                     bus.MemtoReg, bus.Fault, bus.funct3, bus.funct7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One expected cycle: inputs to drive, outputs the controller must show.
  function automatic void push(input logic [31:0] instr, input logic ready, input logic z,
                               input logic [2:0] st, input logic [1:0] aluop,
                               input logic alusrc, input logic [6:0] en);
    ent_t e;
    logic [31:0] ir;
    ir = m_ir;
    e.instr = instr;
    e.ready = ready;
    e.z     = z;
    e.outs  = {st, aluop, alusrc, en, (st == 3'd7), ir[14:12], ir[31:25]};
    e.cyc   = m_cyc;
    e.ret   = m_ret;
    if (st != 3'd7) m_cyc++;
    plan.push_back(e);
  endfunction

  function automatic void model_fault(input int n);
    for (int i = 0; i < n; i++) push(32'hFFFF_FFFF, 1'b1, 1'b1, 3'd7, 2'b00, 1'b0, 7'b0);
  endfunction

  // Expand one instruction into cycles from the per-class rules.
  function automatic void model_instr(input logic [31:0] ins, input int fwait,
                                      input int mwait, input logic z);
    logic [6:0] op;
    logic [2:0] f3;
    bit r, ia, lw, sw, beq;
    op = ins[6:0];
    f3 = ins[14:12];
    r = (op == 7'h33); ia = (op == 7'h13); lw = (op == 7'h03);
    sw = (op == 7'h23); beq = (op == 7'h63);
    for (int i = 0; i < fwait; i++) begin
      push(ins, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0, EN_MRD);
      if (i + 1 == int'(TO)) begin model_fault(3); return; end
    end
    push(ins, 1'b1, 1'b0, 3'd0, 2'b00, 1'b0, EN_MRD | EN_IRW | EN_PCW);
    m_ir = ins;
    push(32'h0, 1'b0, 1'b0, 3'd1, 2'b00, 1'b0, 7'b0);
    if (!(r || ia || lw || sw || beq)) begin model_fault(3); return; end
    if (r)        push(32'h0, 1'b0, 1'b0, 3'd2, 2'b10, 1'b0, 7'b0);
    else if (beq) push(32'h0, 1'b0, z, 3'd2, 2'b01, 1'b0, z ? (EN_PCW | EN_PCS) : 7'b0);
    else          push(32'h0, 1'b0, 1'b0, 3'd2, 2'b00, 1'b1, 7'b0);
    if (beq) begin m_ret++; return; end
    if (ia && f3 != 3'b000) begin model_fault(3); return; end
    if (lw || sw) begin
      for (int i = 0; i < mwait; i++) begin
        push(32'h0, 1'b0, 1'b0, 3'd3, 2'b00, 1'b0, lw ? EN_MRD : EN_MWR);
        if (i + 1 == int'(TO)) begin model_fault(3); return; end
      end
      push(32'h0, 1'b1, 1'b0, 3'd3, 2'b00, 1'b0, lw ? EN_MRD : EN_MWR);
      if (sw) begin m_ret++; return; end
    end
    push(32'h0, 1'b0, 1'b0, 3'd4, 2'b00, 1'b0, lw ? (EN_RW | EN_M2R) : EN_RW);
    m_ret++;
  endfunction

  // Drive up to n planned cycles (n < 0: all), ending just after a rising edge.
  task automatic run_plan(input int n);
    int k = 0;
    while (plan.size() > 0 && (n < 0 || k < n)) begin
      cur = plan.pop_front();
      bus.Instr    = cur.instr;
      bus.MemReady = cur.ready;
      bus.zero     = cur.z;
      cmp_en = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    cmp_en = 1'b0;
  endtask

  task automatic reset_dut();
    cmp_en = 1'b0;
    rst_n = 1'b0;
    bus.Instr = I_ADD;
    bus.MemReady = 1'b1;
    bus.zero = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outs", 32'(dut_outs), 32'h0);
    chk("reset_fault", 32'(bus.Fault), 32'h0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("reset_cycles", cyc_cnt, 32'h0);
    chk("reset_retire", ret_cnt, 32'h0);
`endif
    m_ir = '0;
    m_cyc = 0;
    m_ret = 0;
    rst_n = 1'b1;
  endtask

  // Per-cycle compare against the model plus a few observed-activity tallies.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk($sformatf("outs[%0d]", step), 32'(dut_outs), 32'(cur.outs));
`ifdef MULTICYCLE_CTRL_PERF_EN
      chk($sformatf("cycles[%0d]", step), cyc_cnt, 32'(cur.cyc));
      chk($sformatf("retire[%0d]", step), ret_cnt, 32'(cur.ret));
`endif
      if (bus.State == 3'd3 && bus.MemRead) mem_rd_cyc++;
      if (bus.RegWrite) rw_cyc++;
      step++;
    end
  end

  initial begin
    bus.Instr = '0;
    bus.MemReady = 1'b0;
    bus.zero = 1'b0;
    reset_dut();

    // add x3,x1,x2: four cycles, one RegWrite cycle.
    model_instr(I_ADD, 0, 0, 1'b0);
    chk("add_plan_len", 32'(plan.size()), 32'd4);
    rw_cyc = 0;
    run_plan(-1);
    chk("add_regwrite_cycles", 32'(rw_cyc), 32'd1);

    // lw x5,8(x1) with three MEM wait states: 8 cycles, MEM held 4.
    model_instr(I_LW, 0, 3, 1'b0);
    chk("lw_plan_len", 32'(plan.size()), 32'd8);
    mem_rd_cyc = 0;
    run_plan(-1);
    chk("lw_mem_read_cycles", 32'(mem_rd_cyc), 32'd4);

    // beq taken and not taken, 3 cycles each.
    model_instr(I_BEQ, 0, 0, 1'b1);
    chk("beq_plan_len", 32'(plan.size()), 32'd3);
    model_instr(I_BEQ, 0, 0, 1'b0);
    run_plan(-1);

    model_instr(I_ADDI, 2, 0, 1'b0);
    model_instr(I_SW, 0, 1, 1'b0);
    model_instr(I_SUB, 1, 0, 1'b0);
    model_instr(I_OR, 0, 0, 1'b0);
    run_plan(-1);

    // addi-class opcode with non-zero funct3 faults after EXEC.
    model_instr(I_XORI, 0, 0, 1'b0);
    run_plan(-1);
    chk("xori_fault", 32'(bus.Fault), 32'd1);
    reset_dut();

    // Illegal opcode faults in DECODE; sticky until reset.
    model_instr(I_BAD, 0, 0, 1'b0);
    run_plan(-1);
    chk("illegal_state", 32'(bus.State), 32'd7);
    reset_dut();
    chk("after_reset_state", 32'(bus.State), 32'd0);

    // Fetch never answered: timeout after TO waiting cycles.
    model_instr(I_ADD, 20, 0, 1'b0);
    run_plan(-1);
    reset_dut();

    // Reset in the middle of a store's MEM cycle.
    model_instr(I_SW, 0, 5, 1'b0);
    run_plan(3);
    plan.delete();
    bus.MemReady = 1'b0;
    #1;
    chk("sw_mem_write_before", 32'(bus.MemWrite), 32'd1);
    chk("sw_mem_state_before", 32'(bus.State), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("sw_mem_write_after_rst", 32'(bus.MemWrite), 32'd0);
    chk("sw_state_after_rst", 32'(bus.State), 32'd0);
    reset_dut();

    // Back-to-back add, lw, beq with no wait states.
    model_instr(I_ADD, 0, 0, 1'b0);
    model_instr(I_LW, 0, 0, 1'b0);
    model_instr(I_BEQ, 0, 0, 1'b0);
    chk("perf_plan_len", 32'(plan.size()), 32'd12);
    run_plan(-1);
    chk("perf_back_in_fetch", 32'(bus.State), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_cycles", cyc_cnt, 32'd12);
    chk("perf_retire", ret_cnt, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
